sigmoid: RTL and testbench

Activation stage placed directly downstream of `node`. On the forward path it consumes the node's 16-bit Q8.8 product and emits an 8-bit unsigned activation that the next layer uses as an operand. On the backward path it consumes the downstream error and emits the 16-bit delta into the node's `delta` port. It scales each error by the activation derivative recorded for the matching forward sample. All interfaces are valid/ready streams.

---
 rtl/sigmoid.sv | 124 ++++++++++++
 tb/tb_sigmoid.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sigmoid.sv
// sigmoid: hard-sigmoid activation stage placed downstream of a node.
//   Forward path : 16-bit signed Q8.8 argument -> 8-bit unsigned Q0.8 activation.
//                  Trained samples record a "saturated" flag in a small FIFO.
//   Backward path: 16-bit signed Q8.8 error -> 16-bit signed Q8.8 delta, scaled by
//                  the derivative (1/4 or 0) of the matching forward sample.
// Ports:
//   clock                      single rising-edge clock
//   reset                      synchronous, active-low
//   train                      record a derivative flag for the accepted argument
//   argument_valid/ready/data  product stream in (Q8.8 signed)
//   activation_valid/ready/data activation stream out (Q0.8 unsigned)
//   error_valid/ready/data     error stream in (Q8.8 signed)
//   delta_valid/ready/data     delta stream out (Q8.8 signed)
module sigmoid #(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        train,
   input  logic        argument_valid,
   output logic        argument_ready,
   input  logic [15:0] argument_data,
   output logic        activation_valid,
   input  logic        activation_ready,
   output logic [7:0]  activation_data,
   input  logic        error_valid,
   output logic        error_ready,
   input  logic [15:0] error_data,
   output logic        delta_valid,
   input  logic        delta_ready,
   output logic [15:0] delta_data
);

   localparam int unsigned AW = $clog2(DEPTH);

   // Derivative-flag FIFO: 1 = saturated (f' = 0), 0 = unsaturated (f' = 1/4).
   logic [DEPTH-1:0] flag_mem;
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             flag_full;
   logic             flag_empty;
   logic             head_flag;

   logic signed [16:0] arg_ext;
   logic signed [16:0] s;
   logic               saturated;
   logic [7:0]         act_next;

   logic signed [15:0] err_s;
   logic signed [15:0] err_scaled;

   logic arg_accept;
   logic err_accept;
   logic push;

   assign flag_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign flag_empty = (wr_ptr == rd_ptr);
   assign head_flag  = flag_mem[rd_ptr[AW-1:0]];

   // Hard sigmoid: s = 0.5 + x/4 with floor division, clamped to [0, 0xFF].
   assign arg_ext = {argument_data[15], argument_data};
   assign s       = (arg_ext >>> 2) + 17'sd128;

   always_comb begin
      saturated = 1'b0;
      act_next  = s[7:0];
      if (s <= 17'sd0) begin
         saturated = 1'b1;
         act_next  = '0;
      end else if (s >= 17'sd256) begin
         saturated = 1'b1;
         act_next  = '1;
      end
   end

   assign err_s      = error_data;
   assign err_scaled = err_s >>> 2;

   // Untrained arguments never wait on the FIFO; errors never wait on the forward path.
   assign argument_ready = (!activation_valid || activation_ready) && !(train && flag_full);
   assign error_ready    = (!delta_valid || delta_ready) && !flag_empty;

   assign arg_accept = argument_valid && argument_ready;
   assign err_accept = error_valid && error_ready;
   assign push       = arg_accept && train;

   always_ff @(posedge clock) begin
      if (!reset) begin
         activation_valid <= 1'b0;
         activation_data  <= '0;
         delta_valid      <= 1'b0;
         delta_data       <= '0;
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         flag_mem         <= '0;
      end else begin
         // Forward output register
         if (arg_accept) begin
            activation_valid <= 1'b1;
            activation_data  <= act_next;
         end else if (activation_ready) begin
            activation_valid <= 1'b0;
         end

         // Backward output register
         if (err_accept) begin
            delta_valid <= 1'b1;
            delta_data  <= head_flag ? '0 : err_scaled;
         end else if (delta_ready) begin
            delta_valid <= 1'b0;
         end

         // FIFO: push and pop may both happen in one cycle
         if (push) begin
            flag_mem[wr_ptr[AW-1:0]] <= saturated;
            wr_ptr                   <= wr_ptr + {{AW{1'b0}}, 1'b1};
         end
         if (err_accept) begin
            rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: tb/tb_sigmoid.sv
module tb_sigmoid;

   logic        clock = 1'b0;
   logic        reset;
   logic        train;
   logic        argument_valid;
   logic        argument_ready;
   logic [15:0] argument_data;
   logic        activation_valid;
   logic        activation_ready;
   logic [7:0]  activation_data;
   logic        error_valid;
   logic        error_ready;
   logic [15:0] error_data;
   logic        delta_valid;
   logic        delta_ready;
   logic [15:0] delta_data;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]  act_q[$];
   logic [15:0] del_q[$];

   sigmoid #(.DEPTH(4)) dut (
      .clock            (clock),
      .reset            (reset),
      .train            (train),
      .argument_valid   (argument_valid),
      .argument_ready   (argument_ready),
      .argument_data    (argument_data),
      .activation_valid (activation_valid),
      .activation_ready (activation_ready),
      .activation_data  (activation_data),
      .error_valid      (error_valid),
      .error_ready      (error_ready),
      .error_data       (error_data),
      .delta_valid      (delta_valid),
      .delta_ready      (delta_ready),
      .delta_data       (delta_data)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic send_arg(input logic [15:0] d, input logic tr, input logic [7:0] exp);
      int i;
      argument_valid = 1'b1;
      argument_data  = d;
      train          = tr;
      i = 0;
      while (!argument_ready && i < 20) begin
         step();
         i++;
      end
      if (!argument_ready) begin
         n_cmp++;
         n_bad++;
         $error("FAIL arg_timeout: observed ready 0 after 20 cycles, required 1");
      end else begin
         act_q.push_back(exp);
         step();
         chk("act_latency", {15'd0, activation_valid}, 16'd1);
      end
      argument_valid = 1'b0;
   endtask

   task automatic send_err(input logic [15:0] d, input logic [15:0] exp);
      int i;
      error_valid = 1'b1;
      error_data  = d;
      i = 0;
      while (!error_ready && i < 20) begin
         step();
         i++;
      end
      if (!error_ready) begin
         n_cmp++;
         n_bad++;
         $error("FAIL err_timeout: observed ready 0 after 20 cycles, required 1");
      end else begin
         del_q.push_back(exp);
         step();
         chk("delta_latency", {15'd0, delta_valid}, 16'd1);
      end
      error_valid = 1'b0;
   endtask

   // Scoreboard: outputs are compared when the handshake is about to complete.
   always @(negedge clock) begin
      if (reset === 1'b1 && activation_valid === 1'b1 && activation_ready === 1'b1) begin
         if (act_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL act_extra: observed 0x%0h, required no output", activation_data);
         end else begin
            chk("act_data", {8'd0, activation_data}, {8'd0, act_q.pop_front()});
         end
      end
      if (reset === 1'b1 && delta_valid === 1'b1 && delta_ready === 1'b1) begin
         if (del_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL delta_extra: observed 0x%0h, required no output", delta_data);
         end else begin
            chk("delta_data", delta_data, del_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish by 200000, required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset            = 1'b0;
      train            = 1'b0;
      argument_valid   = 1'b0;
      argument_data    = '0;
      activation_ready = 1'b1;
      error_valid      = 1'b0;
      error_data       = '0;
      delta_ready      = 1'b1;

      // 1. Reset and inference
      step();
      step();
      reset = 1'b1;
      chk("rst_arg_ready", {15'd0, argument_ready}, 16'd1);
      chk("rst_err_ready", {15'd0, error_ready}, 16'd0);
      chk("rst_act_valid", {15'd0, activation_valid}, 16'd0);
      chk("rst_delta_valid", {15'd0, delta_valid}, 16'd0);

      send_arg(16'h0000, 1'b0, 8'h80);
      chk("inf_err_ready", {15'd0, error_ready}, 16'd0);
      send_arg(16'h0100, 1'b0, 8'hC0);
      chk("inf_err_ready", {15'd0, error_ready}, 16'd0);
      send_arg(16'h0200, 1'b0, 8'hFF);
      chk("inf_err_ready", {15'd0, error_ready}, 16'd0);
      send_arg(16'hFE00, 1'b0, 8'h00);
      chk("inf_err_ready", {15'd0, error_ready}, 16'd0);
      send_arg(16'h8000, 1'b0, 8'h00);
      chk("inf_err_ready", {15'd0, error_ready}, 16'd0);
      send_arg(16'h7FFF, 1'b0, 8'hFF);
      chk("inf_err_ready", {15'd0, error_ready}, 16'd0);
      step();

      // 2. Training pairing
      send_arg(16'h0000, 1'b1, 8'h80);
      send_arg(16'h0200, 1'b1, 8'hFF);
      send_arg(16'h0100, 1'b1, 8'hC0);
      send_err(16'h0100, 16'h0040);
      send_err(16'h0100, 16'h0000);
      send_err(16'hFF00, 16'hFFC0);
      send_arg(16'h0000, 1'b1, 8'h80);
      send_err(16'hFFFF, 16'hFFFF);
      step();

      // 3. FIFO full
      send_arg(16'h0000, 1'b1, 8'h80);
      send_arg(16'h0000, 1'b1, 8'h80);
      send_arg(16'h0000, 1'b1, 8'h80);
      send_arg(16'h0000, 1'b1, 8'h80);
      step();
      argument_valid = 1'b1;
      argument_data  = 16'h0100;
      train          = 1'b1;
      chk("full_block", {15'd0, argument_ready}, 16'd0);
      step();
      chk("full_block_hold", {15'd0, argument_ready}, 16'd0);
      error_valid = 1'b1;
      error_data  = 16'h0100;
      chk("full_err_ready", {15'd0, error_ready}, 16'd1);
      del_q.push_back(16'h0040);
      step();
      error_valid = 1'b0;
      chk("full_release", {15'd0, argument_ready}, 16'd1);
      argument_valid = 1'b0;
      send_err(16'h0100, 16'h0040);
      send_err(16'h0100, 16'h0040);
      send_err(16'h0100, 16'h0040);
      error_valid = 1'b1;
      chk("empty_block", {15'd0, error_ready}, 16'd0);
      error_valid = 1'b0;
      step();

      // 4. Back-pressure
      activation_ready = 1'b0;
      send_arg(16'h0100, 1'b0, 8'hC0);
      for (int c = 0; c < 5; c++) begin
         chk("bp_act_valid", {15'd0, activation_valid}, 16'd1);
         chk("bp_act_stable", {8'd0, activation_data}, 16'h00C0);
         chk("bp_arg_ready", {15'd0, argument_ready}, 16'd0);
         step();
      end
      activation_ready = 1'b1;
      step();
      send_arg(16'h0000, 1'b1, 8'h80);
      send_arg(16'h0000, 1'b1, 8'h80);
      delta_ready = 1'b0;
      send_err(16'h0100, 16'h0040);
      for (int c = 0; c < 5; c++) begin
         chk("bp_delta_valid", {15'd0, delta_valid}, 16'd1);
         chk("bp_delta_stable", delta_data, 16'h0040);
         chk("bp_err_ready", {15'd0, error_ready}, 16'd0);
         step();
      end
      delta_ready = 1'b1;
      step();

      // 5. Simultaneous push/pop: queue holds [unsat, sat] before the shared cycle
      send_arg(16'h0200, 1'b1, 8'hFF);
      argument_valid = 1'b1;
      argument_data  = 16'h0100;
      train          = 1'b1;
      error_valid    = 1'b1;
      error_data     = 16'h0100;
      chk("sim_arg_ready", {15'd0, argument_ready}, 16'd1);
      chk("sim_err_ready", {15'd0, error_ready}, 16'd1);
      act_q.push_back(8'hC0);
      del_q.push_back(16'h0040);
      step();
      argument_valid = 1'b0;
      error_valid    = 1'b0;
      chk("sim_act_valid", {15'd0, activation_valid}, 16'd1);
      chk("sim_delta_valid", {15'd0, delta_valid}, 16'd1);
      send_err(16'h0100, 16'h0000);
      send_err(16'h0100, 16'h0040);
      chk("sim_count_empty", {15'd0, error_ready}, 16'd0);
      step();

      // 6. Reset mid-operation with both outputs valid and 3 flags queued
      send_arg(16'h0000, 1'b1, 8'h80);
      send_arg(16'h0000, 1'b1, 8'h80);
      send_arg(16'h0000, 1'b1, 8'h80);
      send_arg(16'h0000, 1'b1, 8'h80);
      delta_ready = 1'b0;
      send_err(16'h0100, 16'h0040);
      activation_ready = 1'b0;
      send_arg(16'h0000, 1'b0, 8'h80);
      chk("pre_rst_err_ready_blocked", {15'd0, error_ready}, 16'd0);
      reset = 1'b0;
      step();
      reset = 1'b1;
      act_q.delete();
      del_q.delete();
      chk("mid_rst_act_valid", {15'd0, activation_valid}, 16'd0);
      chk("mid_rst_delta_valid", {15'd0, delta_valid}, 16'd0);
      chk("mid_rst_err_ready", {15'd0, error_ready}, 16'd0);
      chk("mid_rst_arg_ready", {15'd0, argument_ready}, 16'd1);
      activation_ready = 1'b1;
      delta_ready      = 1'b1;
      send_arg(16'h0000, 1'b0, 8'h80);
      step();
      step();
      chk("act_q_drained", act_q.size()[15:0], 16'd0);
      chk("del_q_drained", del_q.size()[15:0], 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
